// File: rtl/axi_lite_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_write_arbiter_pkg
//   Shared types and constants for the AXI-Lite write arbiter.
//   - state_t : arbiter FSM states (IDLE, SEND, RESP)
//   - BRESP_* : AXI write response encodings
// ---------------------------------------------------------------------------
package axi_lite_write_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_EXOKAY = 2'b01;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;
   localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational arbiter. Picks one requester from req and reports
//   it both as a one-hot grant and as a binary index.
//   Default build: round-robin, the search starts at ptr and wraps.
//   With AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN defined: fixed priority,
//   lowest index wins, and the ptr input does not exist.
// Ports
//   ptr       in   IDX_W     first index searched (round-robin build only)
//   req       in   NUM_REQ   request vector
//   grant     out  NUM_REQ   one-hot grant (zero when no request)
//   grant_idx out  IDX_W     index of the granted requester
//   grant_any out  1         at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
`ifndef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
   input  logic [IDX_W-1:0]   ptr,
`endif
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
`ifdef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
         cand = IDX_W'(i);
`else
         // Modulo keeps the wrap correct for non-power-of-two NUM_REQ.
         cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
`endif
         if (!grant_any && req[cand]) begin
            grant_any   = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_lite_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_write_arbiter
//   Shares one AXI-Lite write master (AW, W, B) between NUM_REQ requesters,
//   one transaction outstanding. FSM IDLE -> SEND -> RESP -> IDLE.
//   Build option: AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN selects fixed
//   priority (lowest index wins) instead of round-robin.
// Ports
//   clock, reset                  rising-edge clock, async active-high reset
//   req_valid/req_ready           per-requester handshake (ready is one-hot)
//   req_addr/req_data/req_strb    packed per-requester payloads
//   done/done_resp                one-hot completion pulse with its BRESP
//   aw*/w*/b*                     AXI-Lite write master channels
// ---------------------------------------------------------------------------
module axi_lite_write_arbiter
   import axi_lite_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_WDATA_WIDTH = 32
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      req_addr,
   input  logic [NUM_REQ*AXI_WDATA_WIDTH-1:0]     req_data,
   input  logic [NUM_REQ*AXI_WDATA_WIDTH/8-1:0]   req_strb,
   output logic [NUM_REQ-1:0]                     done,
   output logic [1:0]                             done_resp,
   output logic                                   awvalid,
   input  logic                                   awready,
   output logic [AXI_ADDR_WIDTH-1:0]              awaddr,
   output logic [2:0]                             awprot,
   output logic                                   wvalid,
   input  logic                                   wready,
   output logic [AXI_WDATA_WIDTH-1:0]             wdata,
   output logic [AXI_WDATA_WIDTH/8-1:0]           wstrb,
   input  logic                                   bvalid,
   output logic                                   bready,
   input  logic [1:0]                             bresp
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int AW    = AXI_ADDR_WIDTH;
   localparam int DW    = AXI_WDATA_WIDTH;
   localparam int SW    = AXI_WDATA_WIDTH / 8;

   state_t               state_q,     state_d;
   logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
   logic [AW-1:0]        addr_q,      addr_d;
   logic [DW-1:0]        data_q,      data_d;
   logic [SW-1:0]        strb_q,      strb_d;
   logic                 aw_done_q,   aw_done_d;
   logic                 w_done_q,    w_done_d;
   logic [NUM_REQ-1:0]   done_q,      done_d;
   logic [1:0]           done_resp_q, done_resp_d;
`ifndef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
   logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
`endif

   logic [NUM_REQ-1:0]   arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
`ifndef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
      .ptr       (rr_ptr_q),
`endif
      .req       (req_valid),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   // Outputs are decoded from flops only; req_ready additionally follows
   // req_valid and is forced low while reset is held.
   always_comb begin
      req_ready = (state_q == IDLE && !reset) ? arb_grant : '0;
      awvalid   = (state_q == SEND) && !aw_done_q;
      wvalid    = (state_q == SEND) && !w_done_q;
      bready    = (state_q == RESP);
      awaddr    = addr_q;
      awprot    = 3'b000;
      wdata     = data_q;
      wstrb     = strb_q;
      done      = done_q;
      done_resp = done_resp_q;
   end

   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      addr_d      = addr_q;
      data_d      = data_q;
      strb_d      = strb_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      done_d      = '0;
      done_resp_d = done_resp_q;
`ifndef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               grant_idx_d = arb_idx;
               addr_d      = req_addr[arb_idx*AW +: AW];
               data_d      = req_data[arb_idx*DW +: DW];
               strb_d      = req_strb[arb_idx*SW +: SW];
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               state_d     = SEND;
`ifndef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
               rr_ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
`endif
            end
         end
         SEND: begin
            // Each channel retires on its own handshake, in any order.
            aw_done_d = aw_done_q | (awvalid & awready);
            w_done_d  = w_done_q  | (wvalid  & wready);
            if (aw_done_d && w_done_d) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bvalid) begin
               done_d[grant_idx_q] = 1'b1;
               done_resp_d         = bresp;
               state_d             = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         strb_q      <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         done_q      <= '0;
         done_resp_q <= BRESP_OKAY;
`ifndef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         strb_q      <= strb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         done_q      <= done_d;
         done_resp_q <= done_resp_d;
`ifndef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_write_arbiter
//   Directed stimulus with a scoreboard: expected grants, AW/W beats and
//   done pulses are queued when stimulus is issued; a monitor pops and
//   compares whenever the DUT presents them. A few cycle-exact checks are
//   made inline for latency and channel-stability behaviour.
//   Honours AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN for the grant-order test.
// ---------------------------------------------------------------------------
module tb_axi_lite_write_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_data;
   logic [N*SW-1:0]   req_strb;
   logic [N-1:0]      done;
   logic [1:0]        done_resp;
   logic              awvalid, awready;
   logic [AW-1:0]     awaddr;
   logic [2:0]        awprot;
   logic              wvalid, wready;
   logic [DW-1:0]     wdata;
   logic [SW-1:0]     wstrb;
   logic              bvalid, bready;
   logic [1:0]        bresp;

   axi_lite_write_arbiter #(
      .NUM_REQ         (N),
      .AXI_ADDR_WIDTH  (AW),
      .AXI_WDATA_WIDTH (DW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_strb  (req_strb),
      .done      (done),
      .done_resp (done_resp),
      .awvalid   (awvalid),
      .awready   (awready),
      .awaddr    (awaddr),
      .awprot    (awprot),
      .wvalid    (wvalid),
      .wready    (wready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .bvalid    (bvalid),
      .bready    (bready),
      .bresp     (bresp)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Slave model configuration.
   int         aw_delay = 0;
   int         w_delay  = 0;
   int         b_delay  = 0;
   logic [1:0] b_resp_cfg = 2'b00;
   bit         drop_en = 1'b1;
   int         grants_seen = 0;

   // Scoreboard queues.
   int               exp_grant[$];
   logic [AW-1:0]    exp_aw[$];
   logic [DW+SW-1:0] exp_w[$];
   logic [5:0]       exp_done[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
      req_strb[i*SW +: SW] = s;
      req_valid[i] = 1'b1;
   endtask

   task automatic expect_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [1:0] r);
      exp_grant.push_back(i);
      exp_aw.push_back(a);
      exp_w.push_back({d, s});
      exp_done.push_back({4'(i), r});
   endtask

   // Wait until every expected event has been observed and no request is left.
   task automatic drain(input string name, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (exp_grant.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0 &&
             exp_done.size() == 0 && req_valid == '0)
            break;
         cyc(1);
      end
      checks++;
      if (k == budget) begin
         errors++;
         $display("FAIL %s timeout pending grant=%0d aw=%0d w=%0d done=%0d required=0",
                  name, exp_grant.size(), exp_aw.size(), exp_w.size(), exp_done.size());
         exp_grant.delete(); exp_aw.delete(); exp_w.delete(); exp_done.delete();
         req_valid = '0;
      end
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   // Slave: responds 2 time units after each rising edge.
   initial begin
      int aw_cnt, w_cnt, b_cnt;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      forever begin
         @(posedge clock);
         #2;
         if (reset) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end else begin
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 1'b0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 1'b0; w_cnt = 0; end
            if (bready) begin
               bvalid = (b_cnt >= b_delay);
               bresp  = bvalid ? b_resp_cfg : 2'b00;
               b_cnt++;
            end else begin
               bvalid = 1'b0; bresp = 2'b00; b_cnt = 0;
            end
         end
      end
   end

   // Requesters drop valid after their acceptance edge when drop_en is set.
   initial begin
      logic [N-1:0] acc;
      forever begin
         @(negedge clock);
         acc = req_ready;
         @(posedge clock);
         #1;
         if (drop_en) req_valid = req_valid & ~acc;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin
      int         e;
      logic [5:0] ed;
      logic [N-1:0] oh;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (req_ready != '0) begin
               grants_seen++;
               if (exp_grant.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_grant actual=%b required=none", req_ready);
               end else begin
                  e = exp_grant.pop_front();
                  oh = '0; oh[e[1:0]] = 1'b1;
                  check("grant", 64'(req_ready), 64'(oh));
               end
            end
            if (awvalid && awready) begin
               if (exp_aw.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_aw actual=%0h required=none", awaddr);
               end else begin
                  check("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
                  check("awprot", 64'(awprot), 64'h0);
               end
            end
            if (wvalid && wready) begin
               if (exp_w.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_w actual=%0h required=none", wdata);
               end else begin
                  check("wdata_wstrb", 64'({wdata, wstrb}), 64'(exp_w.pop_front()));
               end
            end
            if (done != '0) begin
               if (exp_done.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done actual=%b required=none", done);
               end else begin
                  ed = exp_done.pop_front();
                  oh = '0; oh[ed[3:2]] = 1'b1;
                  check("done", 64'(done), 64'(oh));
                  check("done_resp", 64'(done_resp), 64'(ed[1:0]));
                  $display("txn done req=%0d resp=%b", ed[5:2], done_resp);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_valid = '0; req_addr = '0; req_data = '0; req_strb = '0;

      // Reset state.
      @(negedge clock);
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_awvalid",   64'(awvalid),   64'h0);
      check("rst_wvalid",    64'(wvalid),    64'h0);
      check("rst_bready",    64'(bready),    64'h0);
      check("rst_done",      64'(done),      64'h0);
      check("rst_outputs",   64'({done_resp, awaddr, awprot}), 64'h0);
      check("rst_wdata",     64'({wdata, wstrb}), 64'h0);
      cyc(1);
      reset = 1'b0;
      cyc(1);

      // 1: single request, minimum latency.
      set_req(2, 32'h40, 32'hDEADBEEF, 4'hF);
      expect_wr(2, 32'h40, 32'hDEADBEEF, 4'hF, 2'b00);
      @(negedge clock);
      check("t1_c0_ready",   64'(req_ready), 64'h4);
      check("t1_c0_awvalid", 64'(awvalid),   64'h0);
      @(negedge clock);
      check("t1_c1_valids",  64'({awvalid, wvalid}), 64'h3);
      check("t1_c1_awaddr",  64'(awaddr), 64'h40);
      @(negedge clock);
      check("t1_c2_bready",  64'({bready, awvalid, wvalid}), 64'h4);
      @(negedge clock);
      check("t1_c3_done",    64'(done), 64'h4);
      check("t1_c3_resp",    64'(done_resp), 64'h0);
      cyc(1);
      drain("t1_drain", 20);

      // 2: all four valid continuously.
      reset_pulse();
      drop_en = 1'b0;
      begin
         int target;
`ifdef AXI_LITE_WRITE_ARBITER_FIXED_PRIO_EN
         for (int k = 0; k < 3; k++)
            expect_wr(0, 32'h100, 32'hA5A50000, 4'hF, 2'b00);
         target = grants_seen + 3;
`else
         for (int k = 0; k < 5; k++)
            expect_wr(k % 4, 32'(32'h100 + 16 * (k % 4)), 32'(32'hA5A50000 + (k % 4)),
                      ((k % 4) == 1) ? 4'h3 : 4'hF, 2'b00);
         target = grants_seen + 5;
`endif
         for (int i = 0; i < N; i++)
            set_req(i, 32'(32'h100 + 16 * i), 32'(32'hA5A50000 + i), (i == 1) ? 4'h3 : 4'hF);
         for (int k = 0; k < 100 && grants_seen < target; k++) cyc(1);
         check("t2_grant_count", 64'(grants_seen), 64'(target));
      end
      req_valid = '0;
      drop_en = 1'b1;
      drain("t2_drain", 40);

      // 3: awready delayed, wready immediate.
      aw_delay = 5;
      set_req(1, 32'h200, 32'h12345678, 4'hC);
      expect_wr(1, 32'h200, 32'h12345678, 4'hC, 2'b00);
      @(negedge clock);
      check("t3_c0_ready", 64'(req_ready), 64'h2);
      @(negedge clock);
      check("t3_c1_valids", 64'({awvalid, wvalid}), 64'h3);
      for (int c = 2; c <= 6; c++) begin
         @(negedge clock);
         check("t3_aw_hold", 64'({awvalid, wvalid, bready}), 64'h4);
         check("t3_aw_addr", 64'(awaddr), 64'h200);
      end
      @(negedge clock);
      check("t3_c7_resp", 64'({awvalid, bready}), 64'h1);
      cyc(1);
      drain("t3_drain", 20);
      aw_delay = 0;

      // 4: delayed B with SLVERR.
      b_delay = 3;
      b_resp_cfg = 2'b10;
      set_req(0, 32'h300, 32'hCAFEF00D, 4'h5);
      expect_wr(0, 32'h300, 32'hCAFEF00D, 4'h5, 2'b10);
      @(negedge clock);
      check("t4_c0_ready", 64'(req_ready), 64'h1);
      @(negedge clock);
      for (int c = 2; c <= 5; c++) begin
         @(negedge clock);
         check("t4_bready_hold", 64'({bready, done}), 64'h10);
      end
      @(negedge clock);
      check("t4_done", 64'(done), 64'h1);
      check("t4_resp", 64'(done_resp), 64'h2);
      @(negedge clock);
      check("t4_done_once", 64'(done), 64'h0);
      cyc(1);
      drain("t4_drain", 20);
      b_delay = 0;
      b_resp_cfg = 2'b00;

      // 5: reset while in SEND abandons the write.
      aw_delay = 20;
      w_delay  = 20;
      set_req(2, 32'h400, 32'h0BADF00D, 4'hF);
      exp_grant.push_back(2);
      @(negedge clock);
      check("t5_c0_ready", 64'(req_ready), 64'h4);
      @(negedge clock);
      check("t5_c1_send", 64'({awvalid, wvalid}), 64'h3);
      cyc(1);
      reset = 1'b1;
      @(negedge clock);
      check("t5_rst_valids", 64'({awvalid, wvalid, bready}), 64'h0);
      check("t5_rst_regs", 64'({done, awaddr}), 64'h0);
      cyc(1);
      reset = 1'b0;
      aw_delay = 0;
      w_delay  = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         check("t5_no_done", 64'({done, awvalid, wvalid}), 64'h0);
      end
      cyc(1);
      set_req(1, 32'h500, 32'h55AA55AA, 4'hF);
      expect_wr(1, 32'h500, 32'h55AA55AA, 4'hF, 2'b00);
      @(negedge clock);
      check("t5_regrant", 64'(req_ready), 64'h2);
      cyc(1);
      drain("t5_drain", 20);

      // 6: requester 3 granted, then pointer wraps to 0.
      set_req(3, 32'h600, 32'h33333333, 4'hF);
      expect_wr(3, 32'h600, 32'h33333333, 4'hF, 2'b00);
      drain("t6a_drain", 20);
      set_req(0, 32'h700, 32'h00000007, 4'h1);
      set_req(3, 32'h604, 32'h44444444, 4'h8);
      expect_wr(0, 32'h700, 32'h00000007, 4'h1, 2'b00);
      expect_wr(3, 32'h604, 32'h44444444, 4'h8, 2'b00);
      @(negedge clock);
      check("t6_wrap_grant", 64'(req_ready), 64'h1);
      cyc(1);
      drain("t6b_drain", 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
